// File: rtl/full_adder_bitdef.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bitdef
// Description : WIDTH-bit unsigned ripple-carry adder built from full-adder
//               cells, with registered sum and carry-out. The optional
//               two's-complement overflow output is enabled by FA_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module full_adder_bitdef_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic w_p;

    assign w_p = a_i ^ b_i;
    assign s_o = w_p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & w_p);
endmodule

module full_adder_bitdef #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
`ifdef FA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bitdef_cell u_cell (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (w_carry[i]),
            .s_o (w_sum[i]),
            .c_o (w_carry[i+1])
        );
    end

    assign s_d    = w_sum;
    assign cout_d = w_carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef FA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // For WIDTH = 1 this reduces to c[1] ^ 0, since w_carry[0] is tied low.
    assign ovf_d = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder_bitdef.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder_bitdef
// Description : Self-checking bench for full_adder_bitdef at widths 2..32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_bitdef;

    logic clk;
    logic rst;
    logic [1:0]  a2,  b2,  s2;
    logic [3:0]  a4,  b4,  s4;
    logic [7:0]  a8,  b8,  s8;
    logic [15:0] a16, b16, s16;
    logic [31:0] a32, b32, s32;
    logic cout2, cout4, cout8, cout16, cout32;
    logic ovf2, ovf4, ovf8, ovf16, ovf32;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FA_OVF_EN
    full_adder_bitdef #(.WIDTH(2))  u_w2  (.clk(clk), .rst(rst), .a(a2),  .b(b2),  .s(s2),  .ovf(ovf2),  .cout(cout2));
    full_adder_bitdef #(.WIDTH(4))  u_w4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .s(s4),  .ovf(ovf4),  .cout(cout4));
    full_adder_bitdef #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .s(s8),  .ovf(ovf8),  .cout(cout8));
    full_adder_bitdef #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .s(s16), .ovf(ovf16), .cout(cout16));
    full_adder_bitdef #(.WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .s(s32), .ovf(ovf32), .cout(cout32));
`else
    full_adder_bitdef #(.WIDTH(2))  u_w2  (.clk(clk), .rst(rst), .a(a2),  .b(b2),  .s(s2),  .cout(cout2));
    full_adder_bitdef #(.WIDTH(4))  u_w4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .s(s4),  .cout(cout4));
    full_adder_bitdef #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .s(s8),  .cout(cout8));
    full_adder_bitdef #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .s(s16), .cout(cout16));
    full_adder_bitdef #(.WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .s(s32), .cout(cout32));
    assign {ovf2, ovf4, ovf8, ovf16, ovf32} = '0;
`endif

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [14];
    logic [32:0] last_exp [int];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b);
        case (w)
            2:  begin a2  = a[1:0];  b2  = b[1:0];  end
            4:  begin a4  = a[3:0];  b4  = b[3:0];  end
            8:  begin a8  = a[7:0];  b8  = b[7:0];  end
            16: begin a16 = a[15:0]; b16 = b[15:0]; end
            default: begin a32 = a; b32 = b; end
        endcase
    endtask

    function automatic logic [32:0] res(input int w);
        case (w)
            2:  return {cout2,  30'd0, s2};
            4:  return {cout4,  28'd0, s4};
            8:  return {cout8,  24'd0, s8};
            16: return {cout16, 16'd0, s16};
            default: return {cout32, s32};
        endcase
    endfunction

    function automatic logic ovf_of(input int w);
        case (w)
            2:  return ovf2;
            4:  return ovf4;
            8:  return ovf8;
            16: return ovf16;
            default: return ovf32;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{4,  32'd8,          32'd8,          32'd0,          1'b1, 1'b1};
        vecs[1]  = '{4,  32'd7,          32'd1,          32'd8,          1'b0, 1'b1};
        vecs[2]  = '{4,  32'd9,          32'd9,          32'd2,          1'b1, 1'b1};
        vecs[3]  = '{4,  32'd3,          32'd4,          32'd7,          1'b0, 1'b0};
        vecs[4]  = '{4,  32'd15,         32'd15,         32'd14,         1'b1, 1'b0};
        vecs[5]  = '{8,  32'd12,         32'd5,          32'd17,         1'b0, 1'b0};
        vecs[6]  = '{16, 32'd20,         32'd10,         32'd30,         1'b0, 1'b0};
        vecs[7]  = '{32, 32'd50,         32'd43,         32'd93,         1'b0, 1'b0};
        vecs[8]  = '{32, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[9]  = '{32, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, 1'b0};
        vecs[10] = '{2,  32'd2,          32'd1,          32'd3,          1'b0, 1'b0};
        vecs[11] = '{2,  32'd1,          32'd1,          32'd2,          1'b0, 1'b1};
        vecs[12] = '{8,  32'd127,        32'd1,          32'd128,        1'b0, 1'b1};
        vecs[13] = '{16, 32'hFFFF,       32'hFFFF,       32'hFFFE,       1'b1, 1'b0};

        rst = 1'b1;
        {a2, b2, a4, b4, a8, b8, a16, b16, a32, b32} = '0;
        a2 = 2'd3; b2 = 2'd1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;

        // Reset state, held over two edges with non-zero operands present.
        @(posedge clk); #1;
        chk("rst_w2", res(2), 33'd0);
        chk("rst_w32", res(32), 33'd0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst_hold_w2", res(2), 33'd0);
        chk("rst_hold_w32", res(32), 33'd0);
        chk("rst_ovf_w32", {32'd0, ovf_of(32)}, 33'd0);

        @(negedge clk);
        rst = 1'b0;
        a32 = 32'd0; b32 = 32'd0;
        @(posedge clk); #1;
        chk("w2_3p1", res(2), {1'b1, 32'd0});
        chk("w32_zero", res(32), 33'd0);
        last_exp[2]  = {1'b1, 32'd0};
        last_exp[4]  = 33'd0;
        last_exp[8]  = 33'd0;
        last_exp[16] = 33'd0;
        last_exp[32] = 33'd0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].w, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("vec%0d_hold", i), res(vecs[i].w), last_exp[vecs[i].w]);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_sum", i), res(vecs[i].w), {vecs[i].cout, vecs[i].s});
`ifdef FA_OVF_EN
            chk($sformatf("vec%0d_ovf", i), {32'd0, ovf_of(vecs[i].w)}, {32'd0, vecs[i].ovf});
`endif
            last_exp[vecs[i].w] = {vecs[i].cout, vecs[i].s};
        end

        // Reset asserted on the same edge as new operands: value is discarded.
        @(negedge clk);
        rst = 1'b1;
        a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1;
        chk("mid_rst_w8", res(8), 33'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_w8", res(8), {1'b1, 32'd44});
`ifdef FA_OVF_EN
        chk("post_rst_ovf_w8", {32'd0, ovf8}, 33'd0);
`endif

        // Exhaustive 4-bit sweep, new operands every cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [4:0] exp_sum;
                logic       exp_ovf;
                @(negedge clk);
                a4 = 4'(i);
                b4 = 4'(j);
                exp_sum = 5'(i) + 5'(j);
                exp_ovf = (a4[3] == b4[3]) && (exp_sum[3] != a4[3]);
                @(posedge clk); #1;
                chk($sformatf("sweep_%0d_%0d", i, j), res(4), {exp_sum[4], 28'd0, exp_sum[3:0]});
`ifdef FA_OVF_EN
                chk($sformatf("sweep_ovf_%0d_%0d", i, j), {32'd0, ovf4}, {32'd0, exp_ovf});
`else
                if (exp_ovf === 1'bx) chk("sweep_ovf_model", 33'd0, 33'd1);
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
